// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, error word and scheduler state type for the fpu scheduler
package fpu_pkg;

    localparam logic [3:0]  FPU_OP_ADD     = 4'b0000;
    localparam logic [3:0]  FPU_OP_MUL     = 4'b0010;
    localparam logic [3:0]  FPU_OP_DIV     = 4'b0011;

    // Result word presented to a requester when the fpu hangs and is aborted
    localparam logic [31:0] FPU_ERR_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        DRAIN,
        RESPOND
    } sched_state_t;

endpackage

// File: rtl/fpu_sched_rr_pick.sv
// rtl/fpu_sched_rr_pick.sv - combinational round-robin picker
// Ports:
//   i_req          request vector, one bit per requester
//   i_ptr          highest-priority requester index for this pick
//   o_grant        index of the first set request at or above i_ptr, wrapping
//   o_grant_valid  at least one request is set
module rr_pick
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_grant,
    output logic               o_grant_valid
);

    int w_k;

    // Walk NUM_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_k           = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            if (!o_grant_valid && i_req[IDW'(w_k)]) begin
                o_grant_valid = 1'b1;
                o_grant       = IDW'(w_k);
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - round-robin scheduler sharing one fpu between NUM_REQ requesters
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   req_valid/op/a/b, req_ack    per-requester request inputs and latch pulse
//   resp_valid/result/err/ready  response to the owning requester (shared result/err)
//   fpu_*                        operand, clear and handshake signals toward the fpu
module fpu_sched
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 64,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_result,
    output logic                    resp_err,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [3:0]              fpu_operation,
    output logic [31:0]             fpu_data_a,
    output logic [31:0]             fpu_data_b,
    output logic                    fpu_clear,
    output logic                    fpu_input_rdy,
    input  logic                    fpu_input_ack,
    input  logic                    fpu_output_rdy,
    output logic                    fpu_output_ack,
    input  logic [31:0]             fpu_result
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    sched_state_t        r_state,       w_state_nxt;
    logic [IDW-1:0]      r_ptr,         w_ptr_nxt;
    logic [IDW-1:0]      r_owner,       w_owner_nxt;
    logic [NUM_REQ-1:0]  r_req_ack,     w_req_ack_nxt;
    logic [NUM_REQ-1:0]  r_resp_valid,  w_resp_valid_nxt;
    logic [31:0]         r_resp_result, w_resp_result_nxt;
    logic                r_resp_err,    w_resp_err_nxt;
    logic [3:0]          r_op,          w_op_nxt;
    logic [31:0]         r_a,           w_a_nxt;
    logic [31:0]         r_b,           w_b_nxt;
    logic                r_clear,       w_clear_nxt;
    logic                r_irdy,        w_irdy_nxt;
    logic                r_oack,        w_oack_nxt;
    logic [WDW-1:0]      r_wd,          w_wd_nxt;

    logic [IDW-1:0]      w_grant;
    logic                w_grant_valid;
    logic                w_timeout;
    logic                w_abort;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req         (req_valid),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // The watchdog value seen here is the count of ISSUE/WAIT cycles already
    // spent, so aborting on TIMEOUT-1 lands the error response exactly
    // TIMEOUT cycles after input_rdy first went high.
    assign w_timeout = (r_wd >= WDW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_owner_nxt       = r_owner;
        w_req_ack_nxt     = '0;
        w_resp_valid_nxt  = r_resp_valid;
        w_resp_result_nxt = r_resp_result;
        w_resp_err_nxt    = r_resp_err;
        w_op_nxt          = r_op;
        w_a_nxt           = r_a;
        w_b_nxt           = r_b;
        w_clear_nxt       = 1'b0;
        w_irdy_nxt        = r_irdy;
        w_oack_nxt        = r_oack;
        w_wd_nxt          = r_wd;
        w_abort           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_owner_nxt            = w_grant;
                    w_op_nxt               = req_op[{w_grant, 2'b00} +: 4];
                    w_a_nxt                = req_a[{w_grant, 5'b00000} +: 32];
                    w_b_nxt                = req_b[{w_grant, 5'b00000} +: 32];
                    w_req_ack_nxt[w_grant] = 1'b1;
                    w_clear_nxt            = 1'b1;
                    w_state_nxt            = CLEAR;
                end
            end
            CLEAR: begin
                w_irdy_nxt  = 1'b1;
                w_wd_nxt    = '0;
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_wd_nxt = r_wd + WDW'(1);
                if (fpu_input_ack) begin
                    w_irdy_nxt  = 1'b0;
                    w_state_nxt = WAIT;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            WAIT: begin
                w_wd_nxt = r_wd + WDW'(1);
                if (fpu_output_rdy) begin
                    w_resp_result_nxt = fpu_result;
                    w_oack_nxt        = 1'b1;
                    w_state_nxt       = DRAIN;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            DRAIN: begin
                if (!fpu_output_rdy) begin
                    w_oack_nxt       = 1'b0;
                    w_resp_valid_nxt = NUM_REQ'(1) << r_owner;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = RESPOND;
                end
            end
            RESPOND: begin
                if (resp_ready[r_owner]) begin
                    w_resp_valid_nxt = '0;
                    w_resp_err_nxt   = 1'b0;
                    w_ptr_nxt        = (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + IDW'(1);
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Hung fpu: clear it and hand the owner an error response.
        if (w_abort) begin
            w_irdy_nxt        = 1'b0;
            w_oack_nxt        = 1'b0;
            w_clear_nxt       = 1'b1;
            w_resp_err_nxt    = 1'b1;
            w_resp_result_nxt = FPU_ERR_RESULT;
            w_resp_valid_nxt  = NUM_REQ'(1) << r_owner;
            w_state_nxt       = RESPOND;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_req_ack     <= '0;
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_clear       <= 1'b1;
            r_irdy        <= 1'b0;
            r_oack        <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_req_ack     <= w_req_ack_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_resp_result <= w_resp_result_nxt;
            r_resp_err    <= w_resp_err_nxt;
            r_op          <= w_op_nxt;
            r_a           <= w_a_nxt;
            r_b           <= w_b_nxt;
            r_clear       <= w_clear_nxt;
            r_irdy        <= w_irdy_nxt;
            r_oack        <= w_oack_nxt;
            r_wd          <= w_wd_nxt;
        end
    end

    assign req_ack        = r_req_ack;
    assign resp_valid     = r_resp_valid;
    assign resp_result    = r_resp_result;
    assign resp_err       = r_resp_err;
    assign fpu_operation  = r_op;
    assign fpu_data_a     = r_a;
    assign fpu_data_b     = r_b;
    assign fpu_clear      = r_clear;
    assign fpu_input_rdy  = r_irdy;
    assign fpu_output_ack = r_oack;

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - self-checking bench for fpu_sched with an fpu stub and response scoreboard
module tb_fpu_sched;
    import fpu_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;

    localparam int S_IDLE = 0;
    localparam int S_ACK  = 1;
    localparam int S_BUSY = 2;
    localparam int S_OUT  = 3;
    localparam int S_HANG = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [4*NR-1:0]  req_op;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic [NR-1:0]    req_ack;
    logic [NR-1:0]    resp_valid;
    logic [31:0]      resp_result;
    logic             resp_err;
    logic [NR-1:0]    resp_ready;
    logic [3:0]       fpu_operation;
    logic [31:0]      fpu_data_a;
    logic [31:0]      fpu_data_b;
    logic             fpu_clear;
    logic             fpu_input_rdy;
    logic             fpu_input_ack;
    logic             fpu_output_rdy;
    logic             fpu_output_ack;
    logic [31:0]      fpu_result;

    fpu_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ack        (req_ack),
        .resp_valid     (resp_valid),
        .resp_result    (resp_result),
        .resp_err       (resp_err),
        .resp_ready     (resp_ready),
        .fpu_operation  (fpu_operation),
        .fpu_data_a     (fpu_data_a),
        .fpu_data_b     (fpu_data_b),
        .fpu_clear      (fpu_clear),
        .fpu_input_rdy  (fpu_input_rdy),
        .fpu_input_ack  (fpu_input_ack),
        .fpu_output_rdy (fpu_output_rdy),
        .fpu_output_ack (fpu_output_ack),
        .fpu_result     (fpu_result)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   glog[$];
    int   rem[NR];
    int   cyc = 0;

    int          st;
    int          cnt;
    int          lat;
    bit          hang;
    logic [3:0]  s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;

    logic prev_irdy = 1'b0;
    logic prev_rv   = 1'b0;
    logic prev_clr  = 1'b0;
    int   t_irdy, t_rv, t_ack;
    logic clr_at_rv;
    int   clr_pulses;
    int   overlap;

    function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case ({op, a, b})
            {FPU_OP_MUL, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            {FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {FPU_OP_DIV, 32'h4080_0000, 32'h4000_0000}: return 32'h4000_0000;
            {FPU_OP_MUL, 32'h3FC0_0000, 32'h4000_0000}: return 32'h4040_0000;
            {FPU_OP_ADD, 32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;
            default:                                     return a ^ b ^ {28'h0, op};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic raise(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
        req_valid[i]       = 1'b1;
        req_op[4*i +: 4]   = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        rem[i]             = n;
    endtask

    // One clock: score a response handshake due at the coming edge, then
    // react to the new outputs at the falling edge (requesters and fpu stub).
    task automatic step();
        exp_t e;
        if ((resp_valid & resp_ready) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner",  32'(resp_valid), 32'(1 << e.idx));
                chk("resp_result", resp_result, e.res);
                chk("resp_err",    32'(resp_err), 32'(e.err));
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                glog.push_back(i);
                t_ack = cyc;
                if (rem[i] > 0) rem[i]--;
                if (rem[i] == 0) req_valid[i] = 1'b0;
            end
        end
        if (fpu_input_rdy && !prev_irdy) t_irdy = cyc;
        if ((resp_valid != '0) && !prev_rv) begin
            t_rv      = cyc;
            clr_at_rv = fpu_clear;
        end
        if (fpu_clear && !prev_clr) clr_pulses++;
        prev_irdy = fpu_input_rdy;
        prev_rv   = (resp_valid != '0);
        prev_clr  = fpu_clear;
        if (fpu_input_rdy && (st == S_BUSY || st == S_OUT || st == S_HANG)) overlap++;

        if (fpu_clear || reset) begin
            st             = S_IDLE;
            fpu_input_ack  = 1'b0;
            fpu_output_rdy = 1'b0;
        end else begin
            case (st)
                S_IDLE: if (fpu_input_rdy) begin
                    s_op          = fpu_operation;
                    s_a           = fpu_data_a;
                    s_b           = fpu_data_b;
                    fpu_input_ack = 1'b1;
                    if (!hang && lat == 0) begin
                        fpu_output_rdy = 1'b1;
                        fpu_result     = calc(s_op, s_a, s_b);
                    end
                    st = S_ACK;
                end
                S_ACK: begin
                    fpu_input_ack = 1'b0;
                    if (fpu_output_rdy) st = S_OUT;
                    else if (hang) st = S_HANG;
                    else begin
                        cnt = lat;
                        st  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt--;
                    if (cnt <= 0) begin
                        fpu_output_rdy = 1'b1;
                        fpu_result     = calc(s_op, s_a, s_b);
                        st             = S_OUT;
                    end
                end
                S_OUT: if (fpu_output_ack) begin
                    fpu_output_rdy = 1'b0;
                    st             = S_IDLE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("responses_done", 32'(sb.size()), 32'h0);
        step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ack",    32'(req_ack),        32'h0);
        chk("rst_resp_valid", 32'(resp_valid),     32'h0);
        chk("rst_resp_err",   32'(resp_err),       32'h0);
        chk("rst_resp_result", resp_result,        32'h0);
        chk("rst_input_rdy",  32'(fpu_input_rdy),  32'h0);
        chk("rst_output_ack", 32'(fpu_output_ack), 32'h0);
        chk("rst_clear",      32'(fpu_clear),      32'h1);
        chk("rst_operation",  32'(fpu_operation),  32'h0);
        chk("rst_data_a",     fpu_data_a,          32'h0);
        chk("rst_data_b",     fpu_data_b,          32'h0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
        step();
        glog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   t0;
        int   n;
        int   rv_seen;

        vecs[0] = '{1, FPU_OP_MUL, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 2};
        vecs[1] = '{3, FPU_OP_ADD, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 0};
        vecs[2] = '{2, FPU_OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 5};
        vecs[3] = '{0, FPU_OP_DIV, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1};

        reset          = 1'b1;
        req_valid      = '0;
        req_op         = '0;
        req_a          = '0;
        req_b          = '0;
        resp_ready     = '1;
        fpu_input_ack  = 1'b0;
        fpu_output_rdy = 1'b0;
        fpu_result     = '0;
        st             = S_IDLE;
        cnt            = 0;
        lat            = 2;
        hang           = 1'b0;
        s_op           = '0;
        s_a            = '0;
        s_b            = '0;
        t_irdy         = 0;
        t_rv           = 0;
        t_ack          = 0;
        clr_at_rv      = 1'b0;
        clr_pulses     = 0;
        overlap        = 0;
        for (int i = 0; i < NR; i++) rem[i] = 0;

        step();
        step();
        chk_reset_outputs();
        reset = 1'b0;
        step();
        chk("clear_after_reset", 32'(fpu_clear), 32'h0);

        // Single requests from a table, with fixed-latency checks.
        for (int v = 0; v < 4; v++) begin
            lat        = vecs[v].lat;
            glog.delete();
            clr_pulses = 0;
            t0         = cyc;
            raise(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, 1);
            sb.push_back('{vecs[v].idx, vecs[v].res, 1'b0});
            wait_sb(60);
            chk("vec_ack_count", 32'(glog.size()), 32'h1);
            if (glog.size() > 0) chk("vec_grant", 32'(glog[0]), 32'(vecs[v].idx));
            chk("vec_clear_pulses", 32'(clr_pulses), 32'h1);
            chk("vec_ack_latency",  32'(t_ack - t0),  32'h1);
            chk("vec_irdy_latency", 32'(t_irdy - t0), 32'h2);
        end

        // Two requesters in the same cycle after reset: 0 then 2.
        do_reset();
        lat     = 3;
        overlap = 0;
        raise(0, FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1);
        raise(2, FPU_OP_DIV, 32'h4080_0000, 32'h4000_0000, 1);
        sb.push_back('{0, 32'h4000_0000, 1'b0});
        sb.push_back('{2, 32'h4000_0000, 1'b0});
        wait_sb(120);
        chk("pair_grants", 32'(glog.size()), 32'h2);
        if (glog.size() >= 2) begin
            chk("pair_first",  32'(glog[0]), 32'h0);
            chk("pair_second", 32'(glog[1]), 32'h2);
        end
        chk("pair_irdy_overlap", 32'(overlap), 32'h0);

        // All requesters held valid for three rounds.
        do_reset();
        lat = 1;
        for (int i = 0; i < NR; i++) begin
            raise(i, 4'(i + 4), 32'h1000_0000 * i, 32'h0000_0100 + i, 3);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) begin
                sb.push_back('{i, (32'h1000_0000 * i) ^ (32'h0000_0100 + i) ^ (i + 4), 1'b0});
            end
        end
        wait_sb(600);
        chk("rr_grant_count", 32'(glog.size()), 32'(3 * NR));
        for (int k = 0; k < glog.size(); k++) begin
            chk("rr_order", 32'(glog[k]), 32'(k % NR));
        end

        // Hung fpu: watchdog abort, then a normal operation.
        hang       = 1'b1;
        clr_pulses = 0;
        t_irdy     = -1000;
        t_rv       = 0;
        raise(1, FPU_OP_ADD, 32'h1, 32'h2, 1);
        sb.push_back('{1, 32'hFFFF_FFFF, 1'b1});
        wait_sb(100);
        chk("timeout_latency", 32'(t_rv - t_irdy), 32'(TO));
        chk("abort_clear",     32'(clr_at_rv), 32'h1);
        chk("abort_clear_pulses", 32'(clr_pulses), 32'h2);
        hang = 1'b0;
        step();
        raise(2, FPU_OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 1);
        sb.push_back('{2, 32'h4040_0000, 1'b0});
        wait_sb(60);

        // Owner withholds resp_ready for 10 cycles; non-owners are ready.
        resp_ready = 4'b0111;
        lat        = 2;
        raise(3, FPU_OP_ADD, 32'h4040_0000, 32'h3F80_0000, 1);
        sb.push_back('{3, 32'h4080_0000, 1'b0});
        n = 0;
        while (resp_valid == '0 && n < 60) begin
            step();
            n++;
        end
        chk("hold_resp_seen", 32'(resp_valid), 32'h8);
        glog.delete();
        raise(0, FPU_OP_MUL, 32'h4000_0000, 32'h4000_0000, 1);
        sb.push_back('{0, 32'h4080_0000, 1'b0});
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_valid",  32'(resp_valid), 32'h8);
            chk("hold_result", resp_result, 32'h4080_0000);
            chk("hold_err",    32'(resp_err), 32'h0);
        end
        chk("hold_no_ack", 32'(glog.size()), 32'h0);
        resp_ready = '1;
        wait_sb(80);

        // Reset while the scheduler waits on the fpu.
        lat = 8;
        raise(2, FPU_OP_ADD, 32'h1, 32'h1, 1);
        n = 0;
        while (st != S_BUSY && n < 20) begin
            step();
            n++;
        end
        chk("wait_reached", 32'(st), 32'(S_BUSY));
        reset = 1'b1;
        step();
        chk_reset_outputs();
        reset = 1'b0;
        glog.delete();
        rv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (resp_valid != '0) rv_seen++;
        end
        chk("discarded_resp", 32'(rv_seen), 32'h0);
        lat = 2;
        raise(3, FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1);
        raise(0, FPU_OP_DIV, 32'h4080_0000, 32'h4000_0000, 1);
        sb.push_back('{0, 32'h4000_0000, 1'b0});
        sb.push_back('{3, 32'h4000_0000, 1'b0});
        wait_sb(120);
        if (glog.size() >= 2) begin
            chk("post_reset_first",  32'(glog[0]), 32'h0);
            chk("post_reset_second", 32'(glog[1]), 32'h3);
        end else begin
            chk("post_reset_grants", 32'(glog.size()), 32'h2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_sched.md
Name: fpu_sched

Overview:
Shares the single fpu instance between NUM_REQ requesters (decode, load/store pipe, debug port). Requesters are arbitrated round-robin. The block sequences one operation at a time through the fpu's input_rdy/input_ack and output_rdy/output_ack handshakes and returns the result to the owning requester. A watchdog covers a hung fpu by clearing it and returning an error response.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles from fpu_input_rdy rise to fpu_output_rdy before abort
IDW, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  request pending, per requester
req_op  in  4*NUM_REQ  opcode, requester i at [4i+3:4i]
req_a  in  32*NUM_REQ  operand A (IEEE-754 single), [32i+31:32i]
req_b  in  32*NUM_REQ  operand B
req_ack  out  NUM_REQ  one-cycle pulse: request latched; requester may drop or change req_*
resp_valid  out  NUM_REQ  result available for requester i (one-hot or zero)
resp_result  out  32  result word, shared
resp_err  out  1  qualifies resp_valid: 1 = timeout abort, resp_result = 32'hFFFF_FFFF
resp_ready  in  NUM_REQ  requester accepts response
fpu_operation  out  4  to fpu operation
fpu_data_a  out  32  to fpu data_a
fpu_data_b  out  32  to fpu data_b
fpu_clear  out  1  to fpu reset; one-cycle pulse
fpu_input_rdy  out  1  to fpu input_rdy
fpu_input_ack  in  1  from fpu input_ack
fpu_output_rdy  in  1  from fpu output_rdy
fpu_output_ack  out  1  to fpu output_ack
fpu_result  in  32  from fpu result

Behaviour:
- All outputs registered. On reset: state IDLE; pointer = 0; req_ack, resp_valid, resp_err, fpu_input_rdy, fpu_output_ack = 0; fpu_clear = 1 for the reset cycle(s) and 0 after; fpu_operation/data_a/data_b/resp_result = 0; watchdog = 0.
- IDLE: if any req_valid, pick the first set bit at or above pointer, wrapping. Latch op/a/b into fpu_* regs and owner index. Pulse req_ack[owner] next cycle. Go to CLEAR.
- CLEAR (1 cycle): fpu_clear = 1. Next state ISSUE.
- ISSUE: fpu_input_rdy = 1, watchdog counts. On fpu_input_ack = 1: input_rdy drops next cycle, go to WAIT. If fpu_input_ack and fpu_output_rdy are both high in the same cycle, go to WAIT; WAIT then sees output_rdy in its first cycle.
- WAIT: on fpu_output_rdy = 1, capture fpu_result into resp_result, set fpu_output_ack = 1, go to DRAIN.
- DRAIN: hold fpu_output_ack = 1 until fpu_output_rdy = 0, then drop output_ack and go to RESPOND.
- Watchdog: reset on leaving CLEAR; counts in ISSUE/WAIT. On reaching TIMEOUT: abort to RESPOND with resp_err = 1 and resp_result = 32'hFFFF_FFFF, pulse fpu_clear, drop input_rdy/output_ack. DRAIN is not timed.
- RESPOND: resp_valid[owner] = 1; resp_result/resp_err held stable. On resp_ready[owner]: clear resp_valid, set pointer = owner+1 (mod NUM_REQ), go to IDLE. resp_ready of non-owners is ignored.
- Fixed latency, ready fpu, no back-pressure: req_ack at T+1, fpu_input_rdy at T+2. Next grant no earlier than 1 cycle after the response handshake.
- A requester dropping req_valid after req_ack does not cancel the in-flight operation. A new req_valid from the owner during RESPOND waits for arbitration.
- Reset mid-operation: synchronous return to IDLE at the next edge, with reset values above. The pending response is discarded and the pointer returns to 0.
- Opcodes are passed through unchecked. The fpu owns NaN/Inf semantics.

Decomposition:
- fpu_pkg holds:
  - opcode constants FPU_OP_ADD = 4'b0000, FPU_OP_MUL = 4'b0010, FPU_OP_DIV = 4'b0011;
  - FPU_ERR_RESULT = 32'hFFFF_FFFF;
  - typedef enum sched_state_t {IDLE, CLEAR, ISSUE, WAIT, DRAIN, RESPOND}.
- One sub-module rr_pick: combinational round-robin picker with inputs req vector and pointer, outputs grant index and grant_valid. The pointer register lives in fpu_sched.

Test Plan:
- Single request, req 1, MUL, 32'h40000000 x 32'h40000000 with the real fpu -> req_ack[1] pulse, one fpu_clear pulse, resp_valid[1] with resp_result 32'h40800000, resp_err 0.
- req 0 ADD 32'h3F800000 + 32'h3F800000 and req 2 DIV 32'h40800000 / 32'h40000000 raised in the same cycle -> req 0 served first (32'h40000000), then req 2 (32'h40000000); no overlap on fpu_input_rdy.
- All NUM_REQ requesters held valid for 3 rounds -> grant order 0,1,2,3,0,1,2,3,...; no requester is starved.
- Stub fpu never asserts fpu_output_rdy -> resp_err = 1 and resp_result 32'hFFFF_FFFF exactly TIMEOUT cycles after input_rdy rose; fpu_clear pulses; the next request completes normally.
- resp_ready held low 10 cycles -> resp_valid and resp_result stable throughout; no new req_ack is issued meanwhile.
- Reset asserted during WAIT -> the next cycle all outputs are at reset values; the pending result is never presented; a fresh request after reset grants requester 0 first.
